// File: rtl/wb_pkg.sv
// Shared definitions for the writeback select stage: default width, load funct3
// encodings and the conventional writeback source indices.
package wb_pkg;

  localparam int WB_XLEN = 64;

  typedef enum logic [2:0] {
    F3_LB   = 3'b000,
    F3_LH   = 3'b001,
    F3_LW   = 3'b010,
    F3_LD   = 3'b011,
    F3_LBU  = 3'b100,
    F3_LHU  = 3'b101,
    F3_LWU  = 3'b110,
    F3_PASS = 3'b111
  } ld_funct3_e;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC4 = 2;
  localparam int SRC_IMM = 3;

  // Select width leaves room for at least one out-of-range code so a bad
  // select can be flagged even when NUM_SRC is a power of two.
  function automatic int sel_w(input int num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/wb_select_stage_load_extend.sv
// load_extend: aligns raw load data by byte offset and sign/zero-extends it
// according to the RISC-V load funct3. Purely combinational.
module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN = WB_XLEN
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [2:0]      off,
  output logic [XLEN-1:0] ext
);

  function automatic logic [XLEN-1:0] sext(input logic [XLEN-1:0] v, input int bits);
    logic signed [XLEN-1:0] t;
    t = $signed(v << (XLEN - bits));
    return t >>> (XLEN - bits);
  endfunction

  function automatic logic [XLEN-1:0] zext(input logic [XLEN-1:0] v, input int bits);
    return v & ({XLEN{1'b1}} >> (XLEN - bits));
  endfunction

  logic [2:0]      off_eff;
  logic [XLEN-1:0] shifted;

  always_comb begin
    // A 32-bit word only has four byte lanes, so offset bit 2 is meaningless there.
    off_eff = (XLEN == 32) ? {1'b0, off[1:0]} : off;
    shifted = data >> {off_eff, 3'b000};
    ext     = shifted;
    case (ld_funct3_e'(funct3))
      F3_LB:   ext = sext(shifted, 8);
      F3_LH:   ext = sext(shifted, 16);
      F3_LW:   ext = (XLEN > 32) ? sext(shifted, 32) : shifted;
      F3_LBU:  ext = zext(shifted, 8);
      F3_LHU:  ext = zext(shifted, 16);
      F3_LWU:  ext = (XLEN > 32) ? zext(shifted, 32) : shifted;
      default: ext = shifted;
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// Writeback select stage: source mux, load extension, one registered output beat
// with valid/ready. Define WB_SKID_BUF_EN to build the one-entry skid buffer.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter  int XLEN        = WB_XLEN,
  parameter  int NUM_SRC     = 4,
  parameter  int MEM_SRC_IDX = SRC_MEM,
  localparam int SELW        = sel_w(NUM_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  input  logic [SELW-1:0]         src_sel,
  input  logic [2:0]              ld_funct3,
  input  logic [2:0]              ld_off,
  input  logic [4:0]              rd_addr,
  input  logic                    reg_write,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         wb_data,
  output logic [4:0]              wb_rd,
  output logic                    wb_we,
  output logic                    sel_err
);

  logic [XLEN-1:0] sel_data, ext_data, res_data;
  logic            sel_ok, is_mem, res_we, accept;

  logic            vld_p1;
  logic [XLEN-1:0] data_p1;
  logic [4:0]      rd_p1;
  logic            we_p1;
  logic            err_q;

  // Stage p0: select source, extend load data, qualify the write enable.
  always_comb begin
    sel_data = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_sel == SELW'(k)) begin
        sel_data = src_data[k*XLEN +: XLEN];
        sel_ok   = 1'b1;
      end
    end
    is_mem   = (src_sel == SELW'(MEM_SRC_IDX));
    res_data = is_mem ? ext_data : sel_data;
    res_we   = reg_write && (rd_addr != 5'd0) && sel_ok;
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .data   (sel_data),
    .funct3 (ld_funct3),
    .off    (ld_off),
    .ext    (ext_data)
  );

`ifdef WB_SKID_BUF_EN
  logic            skid_vld;
  logic [XLEN-1:0] skid_data;
  logic [4:0]      skid_rd;
  logic            skid_we;

  assign in_ready = !skid_vld;
  assign accept   = in_valid && !skid_vld && !flush;

  // Stage p1: output register fed from the skid entry first, so order is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      rd_p1     <= '0;
      we_p1     <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      skid_rd   <= '0;
      skid_we   <= 1'b0;
    end else if (flush) begin
      vld_p1   <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!vld_p1 || out_ready) begin
      if (skid_vld) begin
        vld_p1   <= 1'b1;
        data_p1  <= skid_data;
        rd_p1    <= skid_rd;
        we_p1    <= skid_we;
        skid_vld <= 1'b0;
      end else if (accept) begin
        vld_p1  <= 1'b1;
        data_p1 <= res_data;
        rd_p1   <= rd_addr;
        we_p1   <= res_we;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      skid_vld  <= 1'b1;
      skid_data <= res_data;
      skid_rd   <= rd_addr;
      skid_we   <= res_we;
    end
  end
`else
  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Stage p1: output register, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      rd_p1   <= '0;
      we_p1   <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= res_data;
      rd_p1   <= rd_addr;
      we_p1   <= res_we;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   err_q <= 1'b0;
    else if (accept && !sel_ok) err_q <= 1'b1;
  end

  assign out_valid = vld_p1;
  assign wb_data   = data_p1;
  assign wb_rd     = rd_p1;
  assign wb_we     = we_p1;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed and randomised bench for wb_select_stage (64-bit and 32-bit instances).
module tb_wb_select_stage;

  localparam int XL = 64;
  localparam int NS = 4;
  localparam int SW = 3;
`ifdef WB_SKID_BUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic             clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic             in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [NS*XL-1:0] src_data = '0;
  logic [SW-1:0]    src_sel = '0;
  logic [2:0]       ld_funct3 = '0, ld_off = '0;
  logic [4:0]       rd_addr = '0, wb_rd;
  logic             reg_write = 1'b0, wb_we, sel_err;
  logic [XL-1:0]    wb_data;

  logic             n_in_valid = 1'b0, n_in_ready, n_out_valid, n_wb_we, n_sel_err;
  logic [NS*32-1:0] n_src_data = '0;
  logic [SW-1:0]    n_src_sel = '0;
  logic [2:0]       n_f3 = '0, n_off = '0;
  logic [31:0]      n_wb_data;
  logic [4:0]       n_wb_rd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {logic [63:0] d; logic [4:0] rd; logic we;} beat_t;
  typedef struct {int sel; logic [63:0] d; logic [2:0] f3; logic [2:0] off; logic [63:0] exp;} ld_vec_t;

  ld_vec_t lv [9] = '{
    '{1, 64'h80F0, 3'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFF0},
    '{1, 64'h80F0, 3'd4, 3'd1, 64'h0000_0000_0000_0080},
    '{1, 64'h80F0, 3'd1, 3'd0, 64'hFFFF_FFFF_FFFF_80F0},
    '{1, 64'h8765_4321_FEDC_BA98, 3'd2, 3'd4, 64'hFFFF_FFFF_8765_4321},
    '{1, 64'h8765_4321_FEDC_BA98, 3'd6, 3'd4, 64'h0000_0000_8765_4321},
    '{1, 64'h8765_4321_FEDC_BA98, 3'd5, 3'd6, 64'h0000_0000_0000_8765},
    '{1, 64'h8765_4321_FEDC_BA98, 3'd3, 3'd0, 64'h8765_4321_FEDC_BA98},
    '{1, 64'h8765_4321_FEDC_BA98, 3'd7, 3'd2, 64'h0000_8765_4321_FEDC},
    '{2, 64'h8765_4321_FEDC_BA98, 3'd0, 3'd3, 64'h8765_4321_FEDC_BA98}
  };

  always #5 clk = ~clk;

  wb_select_stage #(.XLEN(64), .NUM_SRC(4), .MEM_SRC_IDX(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src_data(src_data), .src_sel(src_sel), .ld_funct3(ld_funct3), .ld_off(ld_off),
    .rd_addr(rd_addr), .reg_write(reg_write), .out_valid(out_valid), .out_ready(out_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .sel_err(sel_err)
  );

  wb_select_stage #(.XLEN(32), .NUM_SRC(4), .MEM_SRC_IDX(1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .src_data(n_src_data), .src_sel(n_src_sel), .ld_funct3(n_f3), .ld_off(n_off),
    .rd_addr(rd_addr), .reg_write(reg_write), .out_valid(n_out_valid), .out_ready(1'b1),
    .wb_data(n_wb_data), .wb_rd(n_wb_rd), .wb_we(n_wb_we), .sel_err(n_sel_err)
  );

  function automatic logic [63:0] exp_data(input logic [NS*XL-1:0] s, input int sel,
                                           input logic [2:0] f3, input logic [2:0] off);
    logic [63:0] v;
    if (sel >= NS) return 64'd0;
    v = s[sel*XL +: XL];
    if (sel != 1) return v;
    v = v >> (off * 8);
    case (f3)
      3'd0: return {{56{v[7]}}, v[7:0]};
      3'd1: return {{48{v[15]}}, v[15:0]};
      3'd2: return {{32{v[31]}}, v[31:0]};
      3'd4: return {56'd0, v[7:0]};
      3'd5: return {48'd0, v[15:0]};
      3'd6: return {32'd0, v[31:0]};
      default: return v;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int sel, input logic [63:0] d, input logic [2:0] f3,
                          input logic [2:0] off, input logic [4:0] rd, input logic rw);
    for (int k = 0; k < NS; k++) src_data[k*XL +: XL] = (k == sel) ? d : ~d;
    src_sel = SW'(sel); ld_funct3 = f3; ld_off = off; rd_addr = rd; reg_write = rw;
  endtask

  task automatic test_reset();
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (wb_data !== 64'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", wb_data); end
    n_checks++; if (wb_rd !== 5'd0 || wb_we !== 1'b0) begin n_fail++; $display("FAIL reset_rd_we got %h/%b want 0/0", wb_rd, wb_we); end
    n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got %b want 0", out_valid); end
  endtask

  task automatic test_alu();
    out_ready = 1'b1;
    set_beat(0, 64'h1234, 3'd0, 3'd1, 5'd5, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid got %b want 1", out_valid); end
    n_checks++; if (wb_data !== 64'h1234) begin n_fail++; $display("FAIL alu_data got %h want 1234", wb_data); end
    n_checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd5) begin n_fail++; $display("FAIL alu_we_rd got %b/%0d want 1/5", wb_we, wb_rd); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL alu_retire got %b want 0", out_valid); end
  endtask

  task automatic test_load();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_beat(lv[i].sel, lv[i].d, lv[i].f3, lv[i].off, 5'd1, 1'b1);
      in_valid = 1'b1;
      step();
      n_checks++; if (out_valid !== 1'b1 || wb_data !== lv[i].exp) begin
        n_fail++; $display("FAIL load_vec%0d got v=%b %h want v=1 %h", i, out_valid, wb_data, lv[i].exp);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_rd0_selerr();
    out_ready = 1'b1;
    set_beat(0, 64'hAAAA, 3'd0, 3'd0, 5'd0, 1'b1);
    in_valid = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b1 || wb_we !== 1'b0 || wb_data !== 64'hAAAA) begin
      n_fail++; $display("FAIL rd0 got v=%b we=%b d=%h want 1/0/aaaa", out_valid, wb_we, wb_data);
    end
    n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL rd0_sel_err got %b want 0", sel_err); end
    set_beat(5, 64'h5555, 3'd3, 3'd0, 5'd7, 1'b1);
    step();
    n_checks++; if (out_valid !== 1'b1 || wb_data !== 64'd0 || wb_we !== 1'b0 || wb_rd !== 5'd7) begin
      n_fail++; $display("FAIL badsel got v=%b d=%h we=%b rd=%0d want 1/0/0/7", out_valid, wb_data, wb_we, wb_rd);
    end
    n_checks++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL badsel_err got %b want 1", sel_err); end
    set_beat(0, 64'h77, 3'd0, 3'd0, 5'd3, 1'b1);
    step();
    in_valid = 1'b0;
    n_checks++; if (wb_we !== 1'b1 || wb_data !== 64'h77) begin n_fail++; $display("FAIL after_badsel got we=%b d=%h want 1/77", wb_we, wb_data); end
    step();
    n_checks++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL sel_err_sticky got %b want 1", sel_err); end
  endtask

  task automatic test_stall();
    logic [63:0] q[$];
    logic [63:0] d;
    int tag = 1;
    int delivered = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 1 && c <= 3);
      in_valid  = (tag <= 5);
      d = 64'hC000 | 64'(tag);
      set_beat(0, d, 3'd0, 3'd0, 5'(tag), 1'b1);
      #1;
      if (c == 1) begin
        n_checks++; if (in_ready !== SKID) begin n_fail++; $display("FAIL stall_ready_c1 got %b want %b", in_ready, SKID); end
      end
      if (c == 2 || c == 3) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_c%0d got %b want 0", c, in_ready); end
      end
      if (c >= 1 && c <= 3) begin
        n_checks++; if (out_valid !== 1'b1 || wb_data !== 64'hC001) begin
          n_fail++; $display("FAIL stall_hold_c%0d got v=%b %h want 1 c001", c, out_valid, wb_data);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL stall_spurious got %h want none", wb_data); end
        else begin
          d = q.pop_front();
          if (wb_data !== d) begin n_fail++; $display("FAIL stall_order got %h want %h", wb_data, d); end
        end
        delivered++;
      end
      if (in_valid && in_ready) begin
        q.push_back(64'hC000 | 64'(tag));
        tag++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++; if (delivered != 5 || q.size() != 0) begin
      n_fail++; $display("FAIL stall_count got %0d delivered %0d pending want 5/0", delivered, q.size());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    set_beat(0, 64'hA1, 3'd0, 3'd0, 5'd1, 1'b1);
    in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    set_beat(0, 64'hB2, 3'd0, 3'd0, 5'd2, 1'b1);
    step();
    flush = 1'b1; out_ready = 1'b1;
    set_beat(0, 64'hDEAD, 3'd0, 3'd0, 5'd3, 1'b1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped_%0d got v=%b d=%h want v=0", i, out_valid, wb_data); end
    end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    set_beat(5, 64'h0BAD, 3'd0, 3'd0, 5'd9, 1'b1);
    in_valid = 1'b1;
    step();
    set_beat(3, 64'h0BEE, 3'd0, 3'd0, 5'd9, 1'b1);
    out_ready = 1'b0;
    step();
    n_checks++; if (sel_err !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst got err=%b v=%b want 1/1", sel_err, out_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || wb_data !== 64'd0 || wb_rd !== 5'd0 || wb_we !== 1'b0) begin
      n_fail++; $display("FAIL async_rst got v=%b d=%h rd=%0d we=%b want all 0", out_valid, wb_data, wb_rd, wb_we);
    end
    n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL async_rst_err got %b want 0", sel_err); end
    #1 rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_rst_empty got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_xlen32();
    logic [31:0] d = 32'h8765_4321;
    logic [2:0]  f3s [6] = '{3'd2, 3'd6, 3'd3, 3'd0, 3'd1, 3'd4};
    logic [2:0]  offs[6] = '{3'd0, 3'd0, 3'd0, 3'd5, 3'd2, 3'd7};
    logic [31:0] exps[6] = '{32'h8765_4321, 32'h8765_4321, 32'h8765_4321,
                             32'h0000_0043, 32'hFFFF_8765, 32'h0000_0087};
    for (int k = 0; k < NS; k++) n_src_data[k*32 +: 32] = (k == 1) ? d : ~d;
    n_src_sel = 3'd1;
    for (int i = 0; i < 6; i++) begin
      n_f3 = f3s[i]; n_off = offs[i]; n_in_valid = 1'b1;
      step();
      n_checks++; if (n_out_valid !== 1'b1 || n_wb_data !== exps[i]) begin
        n_fail++; $display("FAIL x32_vec%0d got v=%b %h want 1 %h", i, n_out_valid, n_wb_data, exps[i]);
      end
    end
    n_in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    beat_t q[$];
    beat_t b, e;
    logic  exp_err = 1'b0;
    logic  exp_rdy;
    int    sel;
    for (int c = 0; c < 330; c++) begin
      if (c < 300) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 15) == 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      end
      sel = $urandom_range(0, 4);
      for (int k = 0; k < NS; k++) src_data[k*XL +: XL] = {$urandom, $urandom};
      src_sel = SW'(sel); ld_funct3 = 3'($urandom_range(0, 7)); ld_off = 3'($urandom_range(0, 7));
      rd_addr = 5'($urandom_range(0, 31)); reg_write = 1'($urandom_range(0, 1));
      #1;
      n_checks++; if (out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid_c%0d got %b want %b", c, out_valid, q.size() != 0); end
      exp_rdy = SKID ? (q.size() < 2) : !(q.size() != 0 && !out_ready);
      n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready_c%0d got %b want %b", c, in_ready, exp_rdy); end
      n_checks++; if (sel_err !== exp_err) begin n_fail++; $display("FAIL rnd_err_c%0d got %b want %b", c, sel_err, exp_err); end
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() != 0) begin
          e = q.pop_front();
          n_checks++; if (wb_data !== e.d || wb_rd !== e.rd || wb_we !== e.we) begin
            n_fail++; $display("FAIL rnd_beat_c%0d got %h/%0d/%b want %h/%0d/%b", c, wb_data, wb_rd, wb_we, e.d, e.rd, e.we);
          end
        end
        if (in_valid && in_ready) begin
          b.d  = exp_data(src_data, sel, ld_funct3, ld_off);
          b.rd = rd_addr;
          b.we = reg_write && (rd_addr != 5'd0) && (sel < NS);
          q.push_back(b);
          if (sel >= NS) exp_err = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    n_checks++; if (q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rnd_drain got %0d pending v=%b want 0/0", q.size(), out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_rd0_selerr();
    test_stall();
    test_flush();
    test_async_reset();
    test_xlen32();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
